sqrt_req_master: RTL
====================

Name: sqrt_req_master

Overview:
- Initiator side of the sqrt_conv argument/result protocol.
- Generates argument transactions (arg + arg_valid pulse), waits for each sqrt_valid/sqrt_res response, and checks the result arithmetically.
- Keeps pass/fail/timeout counters.
- Sits in front of sqrt_conv in the integration top and in self-test mode; one transaction outstanding at a time.

Parameters:
- ARG_FIRST, 0, first argument of a sweep (8 bit).
- ARG_LAST, 255, last argument of a sweep (8 bit, must be >= ARG_FIRST).
- TIMEOUT, 32, max cycles in WAIT before declaring a timeout (>= 1).
- GAP, 0, idle cycles inserted between response and next issue.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse, begins a run; ignored unless IDLE
- single  in  1  sampled with start: 1 = single transaction on single_arg, 0 = sweep ARG_FIRST..ARG_LAST
- single_arg  in  8  argument for single mode, sampled with start
- arg  out  8  argument to sqrt_conv
- arg_valid  out  1  one-cycle qualifier for arg
- sqrt_valid  in  1  response qualifier from sqrt_conv
- sqrt_res  in  4  response value, valid when sqrt_valid=1
- busy  out  1  high from the cycle after an accepted start until DONE is left
- done  out  1  one-cycle pulse at end of run
- pass_cnt  out  9  correct responses in current run
- fail_cnt  out  9  wrong responses in current run
- timeout_cnt  out  9  transactions with no response in current run
- spurious_cnt  out  9  sqrt_valid seen outside WAIT (never cleared by start)
- last_res  out  4  most recent captured sqrt_res

Behaviour:
- Reset, synchronous and active-high: state=IDLE; all outputs 0, including arg, all counters and last_res.
- Reset mid-run aborts immediately with no done pulse.
- FSM states: IDLE, ISSUE, WAIT, CHECK, GAPW, DONE.
- IDLE:
  - On start, latch the mode and the current argument (single_arg or ARG_FIRST).
  - Clear pass/fail/timeout counters.
  - Go to ISSUE.
- ISSUE: arg_valid=1 for exactly this cycle with arg=current argument; next state WAIT; clear wait counter.
- arg holds its value outside ISSUE; it changes only when the next transaction is loaded.
- WAIT:
  - If sqrt_valid=1: capture sqrt_res into last_res, go to CHECK.
  - Else increment the wait counter. When it reaches TIMEOUT, increment timeout_cnt and go to advance.
  - A response arriving in the same cycle as the timeout is accepted as a response; sqrt_valid has priority.
- CHECK: compute lo=r*r (8 bit) and hi=(r+1)*(r+1) (9 bit, max 256), with r=last_res.
  - Correct iff lo <= arg < hi; increment pass_cnt, else fail_cnt. Go to advance.
- advance:
  - If single mode, or arg==ARG_LAST: go to DONE.
  - Else arg<=arg+1, then GAPW if GAP>0, else ISSUE.
  - The comparison is made before the increment, so ARG_LAST=255 never wraps to 0.
- GAPW: wait GAP cycles, then ISSUE.
- DONE: done=1 for one cycle; busy deasserts the same cycle; go to IDLE.
- spurious_cnt increments on any sqrt_valid outside WAIT; a response in the cycle immediately after a timeout counts as spurious.
- Counters saturate at 511.
- start while not IDLE: ignored, no effect.
- Latency per transaction: ISSUE→WAIT is 1 cycle, plus the response latency, plus 1 CHECK cycle, plus GAP.

Decomposition:
- Package sqrt_pkg holds:
  - ARG_W=8, RES_W=4, CNT_W=9;
  - enum typedef sqrt_req_state_t {IDLE, ISSUE, WAIT, CHECK, GAPW, DONE};
  - typedefs arg_t and res_t.
- One combinational sub-module, sqrt_range_check (inputs arg, res; output ok), instantiated in CHECK. It is reused by the sqrt_conv binding checker.

Test Plan:
- Single mode, single_arg=50, responder returns 7 after 3 cycles → one arg_valid pulse with arg=50; pass_cnt=1, fail_cnt=0; done 1 cycle after CHECK.
- Full sweep 0..255 against a correct sqrt_conv model (latency 2) → 256 arg_valid pulses, arg incrementing 0..255; pass_cnt=256, fail_cnt=0, timeout_cnt=0; single done; no wrap to 0.
- Single mode, single_arg=16, responder returns 3 → fail_cnt=1, last_res=3. Repeat with arg=15 returning 4 → fail, since 15 < 16.
- No response, TIMEOUT=32 → WAIT lasts exactly 32 cycles; timeout_cnt=1; a late sqrt_valid at cycle 33 gives spurious_cnt=1.
- GAP=4 sweep over ARG_FIRST=254, ARG_LAST=255, response in the cycle of the timeout limit → response accepted; exactly 4 idle cycles between the two arg_valid pulses.
- Synchronous reset asserted during WAIT of arg=100 → next cycle: IDLE, all outputs 0, no done; a start pulse during busy is ignored with counters unchanged.

Source files
------------

// File: rtl/sqrt_pkg.sv
// rtl/sqrt_pkg.sv - shared widths, types and state encoding for the sqrt request master
package sqrt_pkg;

   localparam int ARG_W = 8;
   localparam int RES_W = 4;
   localparam int CNT_W = 9;

   typedef logic [ARG_W-1:0] arg_t;
   typedef logic [RES_W-1:0] res_t;
   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      CHECK,
      GAPW,
      DONE
   } sqrt_req_state_t;

   localparam cnt_t CNT_MAX = '1;

   // Result counters stick at full scale instead of wrapping.
   function automatic cnt_t sat_inc(input cnt_t v);
      return (v == CNT_MAX) ? v : v + cnt_t'(1);
   endfunction

endpackage

// File: rtl/sqrt_range_check.sv
// rtl/sqrt_range_check.sv - combinational check that res is floor(sqrt(arg))
module sqrt_range_check
   import sqrt_pkg::*;
(
   input  logic [ARG_W-1:0] i_arg,
   input  logic [RES_W-1:0] i_res,
   output logic             o_ok
);

   logic [ARG_W-1:0] w_res_ext;
   logic [ARG_W-1:0] w_lo;
   logic [ARG_W:0]   w_r1;
   logic [ARG_W:0]   w_hi;

   // (r+1)^2 reaches 256 for r=15, so the upper bound needs one extra bit.
   assign w_res_ext = {{(ARG_W-RES_W){1'b0}}, i_res};
   assign w_lo      = w_res_ext * w_res_ext;
   assign w_r1      = {1'b0, w_res_ext} + 9'd1;
   assign w_hi      = w_r1 * w_r1;
   assign o_ok      = (w_lo <= i_arg) && ({1'b0, i_arg} < w_hi);

endmodule

// File: rtl/sqrt_req_master.sv
// rtl/sqrt_req_master.sv - issues sqrt arguments, checks responses, keeps pass/fail/timeout counts
module sqrt_req_master
   import sqrt_pkg::*;
#(
   parameter logic [ARG_W-1:0] ARG_FIRST = 8'd0,
   parameter logic [ARG_W-1:0] ARG_LAST  = 8'd255,
   parameter int unsigned      TIMEOUT   = 32,
   parameter int unsigned      GAP       = 0
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_start,
   input  logic             i_single,
   input  logic [ARG_W-1:0] i_single_arg,
   output logic [ARG_W-1:0] o_arg,
   output logic             o_arg_valid,
   input  logic             i_sqrt_valid,
   input  logic [RES_W-1:0] i_sqrt_res,
   output logic             o_busy,
   output logic             o_done,
   output logic [CNT_W-1:0] o_pass_cnt,
   output logic [CNT_W-1:0] o_fail_cnt,
   output logic [CNT_W-1:0] o_timeout_cnt,
   output logic [CNT_W-1:0] o_spurious_cnt,
   output logic [RES_W-1:0] o_last_res
);

   localparam int WAIT_W = $clog2(TIMEOUT + 1);
   localparam int GAP_W  = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LIM = WAIT_W'(TIMEOUT - 1);
   localparam logic [GAP_W-1:0]  GAP_LIM  = GAP_W'((GAP > 0) ? (GAP - 1) : 0);

   sqrt_req_state_t r_state;
   sqrt_req_state_t w_next;
   sqrt_req_state_t w_adv_state;

   logic              r_single;
   logic [ARG_W-1:0]  r_arg;
   logic [RES_W-1:0]  r_last_res;
   logic [WAIT_W-1:0] r_wait_cnt;
   logic [GAP_W-1:0]  r_gap_cnt;
   cnt_t              r_pass_cnt;
   cnt_t              r_fail_cnt;
   cnt_t              r_timeout_cnt;
   cnt_t              r_spurious_cnt;

   logic w_ok;
   logic w_last;
   logic w_timeout;
   logic w_step;

   sqrt_range_check u_range_check (
      .i_arg (r_arg),
      .i_res (r_last_res),
      .o_ok  (w_ok)
   );

   // End-of-run is decided on the current argument, so ARG_LAST=255 never wraps.
   assign w_last    = r_single || (r_arg == ARG_LAST);
   assign w_timeout = (r_state == WAIT) && !i_sqrt_valid && (r_wait_cnt == WAIT_LIM);
   assign w_step    = ((r_state == CHECK) || w_timeout) && !w_last;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_comb begin
      w_next      = r_state;
      w_adv_state = w_last ? DONE : ((GAP > 0) ? GAPW : ISSUE);
      o_arg_valid = 1'b0;
      o_done      = 1'b0;
      o_busy      = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_start) begin
               w_next = ISSUE;
            end
         end
         ISSUE: begin
            o_arg_valid = 1'b1;
            o_busy      = 1'b1;
            w_next      = WAIT;
         end
         WAIT: begin
            o_busy = 1'b1;
            if (i_sqrt_valid) begin
               w_next = CHECK;
            end else if (r_wait_cnt == WAIT_LIM) begin
               w_next = w_adv_state;
            end
         end
         CHECK: begin
            o_busy = 1'b1;
            w_next = w_adv_state;
         end
         GAPW: begin
            o_busy = 1'b1;
            if (r_gap_cnt == GAP_LIM) begin
               w_next = ISSUE;
            end
         end
         DONE: begin
            o_done = 1'b1;
            w_next = IDLE;
         end
         default: begin
            w_next = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_single       <= 1'b0;
         r_arg          <= '0;
         r_last_res     <= '0;
         r_wait_cnt     <= '0;
         r_gap_cnt      <= '0;
         r_pass_cnt     <= '0;
         r_fail_cnt     <= '0;
         r_timeout_cnt  <= '0;
         r_spurious_cnt <= '0;
      end else begin
         if ((r_state == IDLE) && i_start) begin
            r_single      <= i_single;
            r_arg         <= i_single ? i_single_arg : ARG_FIRST;
            r_pass_cnt    <= '0;
            r_fail_cnt    <= '0;
            r_timeout_cnt <= '0;
         end

         if (r_state == ISSUE) begin
            r_wait_cnt <= '0;
         end else if ((r_state == WAIT) && !i_sqrt_valid) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end

         if ((r_state == WAIT) && i_sqrt_valid) begin
            r_last_res <= i_sqrt_res;
         end

         if (w_timeout) begin
            r_timeout_cnt <= sat_inc(r_timeout_cnt);
         end

         if (r_state == CHECK) begin
            if (w_ok) begin
               r_pass_cnt <= sat_inc(r_pass_cnt);
            end else begin
               r_fail_cnt <= sat_inc(r_fail_cnt);
            end
         end

         if (w_step) begin
            r_arg <= r_arg + ARG_W'(1);
         end

         if (r_state == GAPW) begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
         end else begin
            r_gap_cnt <= '0;
         end

         // Any response outside WAIT, including one just after a timeout, is unsolicited.
         if ((r_state != WAIT) && i_sqrt_valid) begin
            r_spurious_cnt <= sat_inc(r_spurious_cnt);
         end
      end
   end

   assign o_arg          = r_arg;
   assign o_last_res     = r_last_res;
   assign o_pass_cnt     = r_pass_cnt;
   assign o_fail_cnt     = r_fail_cnt;
   assign o_timeout_cnt  = r_timeout_cnt;
   assign o_spurious_cnt = r_spurious_cnt;

endmodule
